// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline flow controller for the RISC-V core.
// Decides each cycle whether PC and IF/ID advance, hold or flush, from
// load-use hazards, taken branches/JAL, data-memory wait and HALT.
// HALT drains in-flight instructions before freezing the core.
// Optional build macro HAZARD_SEQ_PERF_EN adds the stall_cycles and
// redirect_count performance counter outputs.
module hazard_sequencer #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int DRAIN_DEPTH      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        id_halt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_en,
    output logic        halted
`ifdef HAZARD_SEQ_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // The cycle that accepts a hazard or HALT is itself the first
    // non-advancing cycle, so the counters are loaded with (length - 2)
    // and the extra state is left when the counter reads zero.
    localparam logic [2:0] STALL_LOAD = 3'((LOAD_USE_BUBBLES > 1) ? (LOAD_USE_BUBBLES - 2) : 0);
    localparam logic [2:0] DRAIN_LOAD = 3'((DRAIN_DEPTH > 1) ? (DRAIN_DEPTH - 2) : 0);

    state_t      r_state;
    state_t      w_stateNext;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cntNext;
    logic        w_loadUse;
    logic        w_redirectTaken;

    assign w_loadUse = ex_memread && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // State register and sequencing counter; reset aborts any stall or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and flow-control outputs, all decided in the same cycle as the cause.
    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_redirectTaken = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        pipe_en         = 1'b1;
        halted          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_en    = 1'b0;
                end else if (ex_redirect) begin
                    ifid_flush      = 1'b1;
                    idex_flush      = 1'b1;
                    w_redirectTaken = 1'b1;
                end else if (id_halt) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (DRAIN_DEPTH == 1) begin
                        w_stateNext = ST_HALTED;
                        w_cntNext   = 3'd0;
                    end else begin
                        w_stateNext = ST_DRAIN;
                        w_cntNext   = DRAIN_LOAD;
                    end
                end else if (w_loadUse) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        w_stateNext = ST_STALL;
                        w_cntNext   = STALL_LOAD;
                    end
                end
            end
            ST_STALL, ST_DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                pipe_en    = !mem_busy;
                if (!mem_busy) begin
                    if (r_cnt == 3'd0) begin
                        w_stateNext = (r_state == ST_DRAIN) ? ST_HALTED : ST_RUN;
                    end else begin
                        w_cntNext = r_cnt - 3'd1;
                    end
                end
            end
            ST_HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_en    = 1'b0;
                halted     = 1'b1;
            end
            default: begin
                w_stateNext = ST_RUN;
                w_cntNext   = 3'd0;
            end
        endcase
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
        end
    end

`ifdef HAZARD_SEQ_PERF_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_redirectCount;

    // Saturating performance counters for non-advancing cycles and accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles   <= 32'd0;
            r_redirectCount <= 32'd0;
        end else begin
            if (!pc_write && (r_state != ST_HALTED) && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (w_redirectTaken && (r_redirectCount != 32'hFFFF_FFFF)) begin
                r_redirectCount <= r_redirectCount + 32'd1;
            end
        end
    end

    assign stall_cycles   = r_stallCycles;
    assign redirect_count = r_redirectCount;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: scoreboard bench for hazard_sequencer.
// Directed scenarios followed by randomized episodes; expected outputs come
// from a counter-based reference model and are checked by a separate monitor.
module tb_hazard_sequencer;

    localparam int LUB = 2;
    localparam int DD  = 3;

    typedef struct packed {
        logic       rstN;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       usesRs2;
        logic       halt;
        logic [4:0] exRd;
        logic       memread;
        logic       redirect;
        logic       busy;
    } stim_t;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic ifidFlush;
        logic idexFlush;
        logic pipeEn;
        logic halted;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs2 = 1'b0;
    logic       id_halt = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_memread = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       pipe_en;
    logic       halted;
`ifdef HAZARD_SEQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;
    logic [31:0] expStallQ[$];
    logic [31:0] expRedirQ[$];
`endif

    outs_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: remaining bubble/drain cycles plus a halted flag.
    int          mStall = 0;
    int          mDrain = 0;
    bit          mHalted = 1'b0;
    logic [31:0] mStallCnt = '0;
    logic [31:0] mRedirCnt = '0;

    hazard_sequencer #(
        .LOAD_USE_BUBBLES(LUB),
        .DRAIN_DEPTH(DD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt),
        .ex_rd(ex_rd),
        .ex_memread(ex_memread),
        .ex_redirect(ex_redirect),
        .mem_busy(mem_busy),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .pipe_en(pipe_en),
        .halted(halted)
`ifdef HAZARD_SEQ_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.rstN = 1'b1;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    // Computes this cycle's expected outputs, queues them, then advances the model.
    task automatic modelStep(input stim_t s);
        outs_t e;
        bit    wasHalted;
        bit    loadUse;
        bit    redirTaken;
        e          = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0,
                       idexFlush: 1'b0, pipeEn: 1'b1, halted: 1'b0};
        redirTaken = 1'b0;
        if (!s.rstN) begin
            mStall    = 0;
            mDrain    = 0;
            mHalted   = 1'b0;
            mStallCnt = '0;
            mRedirCnt = '0;
            e = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b1,
                  idexFlush: 1'b1, pipeEn: 1'b0, halted: 1'b0};
            expQ.push_back(e);
`ifdef HAZARD_SEQ_PERF_EN
            expStallQ.push_back(32'd0);
            expRedirQ.push_back(32'd0);
`endif
            return;
        end
`ifdef HAZARD_SEQ_PERF_EN
        expStallQ.push_back(mStallCnt);
        expRedirQ.push_back(mRedirCnt);
`endif
        wasHalted = mHalted;
        loadUse   = s.memread && (s.exRd != 0) &&
                    ((s.exRd == s.rs1) || (s.usesRs2 && (s.exRd == s.rs2)));
        if (mHalted) begin
            e = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                  idexFlush: 1'b0, pipeEn: 1'b0, halted: 1'b1};
        end else if (mDrain > 0 || mStall > 0) begin
            e.pcWrite   = 1'b0;
            e.ifidWrite = 1'b0;
            e.idexFlush = 1'b1;
            e.pipeEn    = !s.busy;
            if (!s.busy) begin
                if (mDrain > 0) begin
                    mDrain--;
                    if (mDrain == 0) mHalted = 1'b1;
                end else begin
                    mStall--;
                end
            end
        end else if (s.busy) begin
            e.pcWrite   = 1'b0;
            e.ifidWrite = 1'b0;
            e.pipeEn    = 1'b0;
        end else if (s.redirect) begin
            e.ifidFlush = 1'b1;
            e.idexFlush = 1'b1;
            redirTaken  = 1'b1;
        end else if (s.halt) begin
            e.pcWrite   = 1'b0;
            e.ifidWrite = 1'b0;
            e.idexFlush = 1'b1;
            mDrain      = DD - 1;
            if (DD == 1) mHalted = 1'b1;
        end else if (loadUse) begin
            e.pcWrite   = 1'b0;
            e.ifidWrite = 1'b0;
            e.idexFlush = 1'b1;
            mStall      = LUB - 1;
        end
        if (!e.pcWrite && !wasHalted && mStallCnt != 32'hFFFF_FFFF) mStallCnt++;
        if (redirTaken && mRedirCnt != 32'hFFFF_FFFF) mRedirCnt++;
        expQ.push_back(e);
    endtask

    // Drives one cycle of inputs, records the expectation and steps to the next cycle.
    task automatic applyStimulus(input stim_t s);
        rst_n       = s.rstN;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_uses_rs2 = s.usesRs2;
        id_halt     = s.halt;
        ex_rd       = s.exRd;
        ex_memread  = s.memread;
        ex_redirect = s.redirect;
        mem_busy    = s.busy;
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleStim());
    endtask

    task automatic applyReset(input int n);
        stim_t s;
        s = idleStim();
        s.rstN = 1'b0;
        for (int i = 0; i < n; i++) applyStimulus(s);
    endtask

    task automatic randomCycle();
        stim_t s;
        s          = idleStim();
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.exRd     = 5'($urandom_range(0, 3));
        s.usesRs2  = ($urandom_range(0, 1) == 1);
        s.memread  = ($urandom_range(0, 99) < 40);
        s.busy     = ($urandom_range(0, 99) < 15);
        s.redirect = (mStall == 0) && ($urandom_range(0, 99) < 15);
        s.halt     = ($urandom_range(0, 99) < 2);
        applyStimulus(s);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation mid-cycle.
    always @(negedge clk) begin
        outs_t want;
        outs_t got;
        if (expQ.size() > 0) begin
            want = expQ.pop_front();
            got  = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en, halted};
            checkOutput("ctrl{pcW,ifidW,ifidF,idexF,pipeEn,halted}", 32'(got), 32'(want));
`ifdef HAZARD_SEQ_PERF_EN
            checkOutput("stall_cycles", stall_cycles, expStallQ.pop_front());
            checkOutput("redirect_count", redirect_count, expRedirQ.pop_front());
`endif
        end
    end

    initial begin
        stim_t s;
        @(posedge clk);
        #1;
        applyReset(2);

        // Load-use on rs1: two bubbles, then the PC advances again.
        s = idleStim(); s.memread = 1'b1; s.exRd = 5'd5; s.rs1 = 5'd5;
        applyStimulus(s);
        s = idleStim(); s.rs1 = 5'd5;
        applyStimulus(s);
        applyStimulus(s);
        applyIdle(1);

        // Load-use false cases: x0 destination, and rs2 match while rs2 is unused.
        s = idleStim(); s.memread = 1'b1; s.exRd = 5'd0; s.rs1 = 5'd0;
        applyStimulus(s);
        s = idleStim(); s.memread = 1'b1; s.exRd = 5'd5; s.rs1 = 5'd1; s.rs2 = 5'd5;
        applyStimulus(s);
        s.usesRs2 = 1'b1;
        applyStimulus(s);
        applyIdle(2);

        // Redirect squashes a HALT arriving in the same cycle.
        s = idleStim(); s.redirect = 1'b1; s.halt = 1'b1;
        applyStimulus(s);
        applyIdle(2);

        // HALT drain with a busy cycle right after acceptance.
        s = idleStim(); s.halt = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.busy = 1'b1; s.redirect = 1'b1;
        applyStimulus(s);
        applyIdle(4);
        applyReset(1);

        // Busy cycle inside a load-use stall stretches it by one cycle.
        s = idleStim(); s.memread = 1'b1; s.exRd = 5'd7; s.rs2 = 5'd7; s.usesRs2 = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.busy = 1'b1;
        applyStimulus(s);
        applyIdle(3);

        // Reset asserted in the middle of a drain, then normal running.
        s = idleStim(); s.halt = 1'b1;
        applyStimulus(s);
        applyIdle(1);
        applyReset(2);
        s = idleStim(); s.redirect = 1'b1;
        applyStimulus(s);
        applyIdle(3);

        // Randomized episodes, each starting from reset.
        for (int ep = 0; ep < 8; ep++) begin
            applyReset(2);
            for (int c = 0; c < 250; c++) randomCycle();
        end

        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
